// File: rtl/debounce_pkg.sv
// Shared state encoding and default parameter values for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Metastability synchronizer: STAGES-deep flop chain, q lags d by STAGES edges.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounced push-button level; out follows a held raw_in level after SYNC_STAGES+DEBOUNCE_CYCLES edges.
// Moore FSM: out/busy come from the registered state only, never from raw_in.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic out,
  output logic busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_sync;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (raw_in),
    .q    (w_sync)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The count saturates at CNT_LAST because reaching it always leaves the CHK state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    out         = 1'b0;
    busy        = 1'b0;
    case (r_state)
      LOW: begin
        if (w_sync) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      CHK_HIGH: begin
        busy = 1'b1;
        if (!w_sync) begin
          w_state_nxt = LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HIGH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HIGH: begin
        out = 1'b1;
        if (!w_sync) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = '0;
        end
      end
      CHK_LOW: begin
        out  = 1'b1;
        busy = 1'b1;
        if (w_sync) begin
          w_state_nxt = HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = LOW;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOW;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 100-unit clock).
// Expected vectors are bit-per-edge, LSB = first edge of the segment.
module tb_button_debounce;

  logic clock = 1'b0;
  logic reset;
  logic raw_in;
  logic out;
  logic busy;

  int tests = 0;
  int fails = 0;
  logic last_out = 1'b0;
  int pulses = 0;

  always #50 clock = ~clock;

  button_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .raw_in(raw_in),
    .out   (out),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive raw_in, let one rising edge sample it, then observe 1 unit later.
  // Also models the downstream one-press stage as a rising-edge detector on out.
  task automatic step(input logic r);
    raw_in = r;
    @(posedge clock);
    #1;
    if (out && !last_out) pulses++;
    last_out = out;
  endtask

  task automatic run(input string tag, input int n, input logic [31:0] r,
                     input logic [31:0] eo, input logic [31:0] eb);
    for (int i = 0; i < n; i++) begin
      step(r[i]);
      check($sformatf("%s.out[%0d]", tag, i), out, eo[i]);
      check($sformatf("%s.busy[%0d]", tag, i), busy, eb[i]);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 1'b1;

    // Reset held 5 cycles with raw_in high: outputs stay low.
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check($sformatf("rst.out[%0d]", i), out, 1'b0);
      check($sformatf("rst.busy[%0d]", i), busy, 1'b0);
    end
    reset = 1'b0;
    // Qualification counted from first post-reset edge: out rises on edge 7.
    run("rst_rel", 10, 'b1111111111, 'b1111000000, 'b0000111100);

    // Clean release and press.
    run("rel1",  10, 'b0000000000, 'b0000111111, 'b0000111100);
    run("press", 10, 'b1111111111, 'b1111000000, 'b0000111100);

    // Short low dip while high aborts back to HIGH; next release restarts the count.
    run("dip",   8, 'b11111100, 'b11111111, 'b00001100);
    run("rel2", 10, 'b0000000000, 'b0000111111, 'b0000111100);

    // Bounce 1,0,1,1,0,1,1,1,1,1 then held high.
    run("bounce", 14, 'b11111111101101, 'b11100000000000, 'b00011110110100);
    run("rel3",   10, 'b0000000000, 'b0000111111, 'b0000111100);

    // 4-cycle pulse rejected, 5-cycle pulse accepted then released.
    run("glitch4", 10, 'b0000001111, 'b0000000000, 'b0000111100);
    run("glitch5", 14, 'b00000000011111, 'b00011111000000, 'b00011110111100);

    // Reset during CHK_HIGH.
    run("pre_rst", 4, 'b1111, 'b0000, 'b1100);
    reset = 1'b1;
    step(1'b1);
    check("rst_chk.out", out, 1'b0);
    check("rst_chk.busy", busy, 1'b0);
    reset = 1'b0;
    run("post_rst", 4, 'b0000, 'b0000, 'b0000);

    // Reset while out is high.
    run("press2", 10, 'b1111111111, 'b1111000000, 'b0000111100);
    reset = 1'b1;
    step(1'b1);
    check("rst_high.out", out, 1'b0);
    check("rst_high.busy", busy, 1'b0);
    reset = 1'b0;
    run("post_rst2", 4, 'b0000, 'b0000, 'b0000);

    // Held 20 cycles: out stays high, downstream sees exactly one rising edge.
    pulses = 0;
    run("hold", 20, 'b11111111111111111111, 'b11111111111111000000, 'b00000000000000111100);
    check_int("one_press_pulses", pulses, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on raw_in; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples beyond the first that are required to change out; legal range 1..2^20.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port raw_in  input  1  asynchronous, bouncy push-button level.
REQ-006 Port out  output  1  debounced level; feeds the downstream one-press pulse stage's `in`.
REQ-007 Port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-008 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) is used by the FSM.
REQ-009 The FSM SHALL have four states: LOW (out=0, busy=0), CHK_HIGH (out=0, busy=1), HIGH (out=1, busy=0), CHK_LOW (out=1, busy=1).
REQ-010 out and busy SHALL be decoded from the registered state only (Moore); no combinational path from raw_in.
REQ-011 LOW: sync=1 -> CHK_HIGH with cnt<=0; sync=0 -> stay.
REQ-012 CHK_HIGH: sync=0 -> LOW; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH; sync=1 otherwise -> stay, cnt<=cnt+1.
REQ-013 HIGH and CHK_LOW SHALL mirror REQ-011/REQ-012 with sync polarity inverted (HIGH->CHK_LOW on sync=0; CHK_LOW->HIGH on sync=1; CHK_LOW->LOW on count completion).
REQ-014 cnt width SHALL be max(1, $clog2(DEBOUNCE_CYCLES)); cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
REQ-015 Latency: if raw_in is first sampled at a new level on edge k and held, out SHALL change on edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-016 Filter: a raw_in excursion of DEBOUNCE_CYCLES or fewer cycles SHALL NOT change out; one of DEBOUNCE_CYCLES+1 or more cycles SHALL.
REQ-017 Any reversal of sync during a CHK state SHALL abort qualification, return to the prior stable state, and leave out unchanged; the next qualification restarts cnt from 0.
REQ-018 Holding raw_in indefinitely SHALL keep out at a constant level; there SHALL be no auto-repeat or pulsing.
REQ-019 DEBOUNCE_CYCLES=1 SHALL be supported; CHK states then last exactly one cycle.

Reset
REQ-020 While reset=1 at a rising edge: all sync flops<=0, state<=LOW, cnt<=0; out=0 and busy=0 from the following cycle.
REQ-021 Reset asserted during CHK_HIGH, HIGH or CHK_LOW SHALL force LOW on that edge, with no intermediate state.
REQ-022 After reset release with raw_in already high, the block SHALL qualify normally per REQ-015, counted from the first post-reset edge.

Structure
REQ-023 Package debounce_pkg SHALL hold the state enum typedef (LOW, CHK_HIGH, HIGH, CHK_LOW) and the default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-024 The synchronizer SHALL be a sub-module sync_chain (parameter STAGES; ports clock, reset, d, q), instantiated once.
REQ-025 Counter and FSM SHALL reside in button_debounce, with one clocked process and one combinational next-state process.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clock period 100)
REQ-026 Reset held 5 cycles with raw_in=1 -> out=0 and busy=0 throughout reset; after release, out=1 on the 6th edge after raw_in is first sampled.
REQ-027 Clean press: raw_in 0->1, held 10 cycles -> busy=1 for 4 cycles, out rises 6 edges after raw_in is first sampled high; release -> out falls 6 edges after raw_in is first sampled low.
REQ-028 Bounce: raw_in toggles 1,0,1,1,0,1,1,1,1,1 -> out stays 0 until 5 consecutive high samples have reached sync, then rises exactly once.
REQ-029 Glitch rejection: 4-cycle high pulse from LOW -> out never rises and busy returns to 0; 5-cycle pulse -> out rises and later falls.
REQ-030 Reset mid-qualification: assert reset during CHK_HIGH (busy=1) -> out=0, busy=0 next cycle; with reset asserted while out=1 -> out=0 next cycle.
REQ-031 Chain check: button_debounce.out drives the one-press stage with raw_in held 20 cycles -> exactly one 1-cycle pulse downstream.
